// File: rtl/decimal_to_accel.sv
// Signed 4-digit BCD mg to accelerometer register-pair encoder.
// Reverse double-dabble conversion behind a start/busy/done handshake.
module decimal_to_accel (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  thousands,
  input  logic [3:0]  hundreds,
  input  logic [3:0]  tens,
  input  logic [3:0]  ones,
  input  logic        negative,
  output logic [15:0] Accel_Data,
  output logic        busy,
  output logic        done,
  output logic        bcd_err,
  output logic        sat
);

  localparam int unsigned BCD_W   = 16;
  localparam int unsigned ACC_W   = 14;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned VAL_W   = 10;
  localparam int unsigned CNTS_W  = 12;
  localparam int unsigned NDIGITS = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_SHIFT,
    S_SCALE,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               neg_q, neg_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [15:0]        data_q, data_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               sat_q, sat_d;

  logic [BCD_W-1:0]   bcd_sh;
  logic [CNTS_W-1:0]  counts;
  logic [VAL_W-1:0]   mag10;
  logic [VAL_W-1:0]   value;
  logic               digit_bad;
  logic               accept;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      bcd_q   <= '0;
      neg_q   <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      neg_q   <= neg_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      sat_q   <= sat_d;
    end
  end

  // Next-state and datapath logic
  always_comb begin
    state_d   = state_q;
    bcd_d     = bcd_q;
    neg_d     = neg_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;
    sat_d     = sat_q;
    bcd_sh    = '0;
    counts    = '0;
    mag10     = '0;
    value     = '0;
    accept    = 1'b0;
    digit_bad = 1'b0;

    for (int i = 0; i < NDIGITS; i++) begin
      if (bcd_q[4*i +: 4] > 4'd9) digit_bad = 1'b1;
    end

    case (state_q)
      S_IDLE: accept = start;

      // The edge leaving DONE may already accept the next request
      S_DONE: begin
        state_d = S_IDLE;
        accept  = start;
      end

      S_CHECK: begin
        sat_d = 1'b0;
        if (digit_bad) begin
          err_d   = 1'b1;
          state_d = S_SCALE;
        end else begin
          err_d   = 1'b0;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end

      S_SHIFT: begin
        bcd_sh = {1'b0, bcd_q[BCD_W-1:1]};
        for (int i = 0; i < NDIGITS; i++) begin
          if (bcd_sh[4*i+3]) bcd_sh[4*i +: 4] = bcd_sh[4*i +: 4] - 4'd3;
        end
        bcd_d = bcd_sh;
        // All 14 magnitude bits are in place after 14 shifts; hold afterwards
        if (cnt_q < CNT_W'(ACC_W)) acc_d = {bcd_q[0], acc_q[ACC_W-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(BCD_W - 1)) state_d = S_SCALE;
      end

      // Invalid-digit requests pass through here without touching the result
      S_SCALE: begin
        if (!err_q) begin
          counts = CNTS_W'(acc_q >> 2);
          if (neg_q) begin
            if (counts > CNTS_W'(512)) begin
              mag10 = VAL_W'(512);
              sat_d = 1'b1;
            end else begin
              mag10 = VAL_W'(counts);
            end
            value = VAL_W'(~mag10 + VAL_W'(1));
          end else begin
            if (counts > CNTS_W'(511)) begin
              mag10 = VAL_W'(511);
              sat_d = 1'b1;
            end else begin
              mag10 = VAL_W'(counts);
            end
            value = mag10;
          end
          data_d = {value[2:0], 5'b0_0000, value[9], value[9:3]};
        end
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_DONE;
      end

      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      bcd_d   = {thousands, hundreds, tens, ones};
      neg_d   = negative;
      busy_d  = 1'b1;
      state_d = S_CHECK;
    end
  end

  assign Accel_Data = data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign bcd_err    = err_q;
  assign sat        = sat_q;

endmodule

// File: tb/tb_decimal_to_accel.sv
// Self-checking bench for decimal_to_accel: cycle-accurate expectation
// tracking, literal pins on the model, and a full round-trip decode sweep.
module tb_decimal_to_accel;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  thousands, hundreds, tens, ones;
  logic        negative;
  logic [15:0] Accel_Data;
  logic        busy, done, bcd_err, sat;

  decimal_to_accel dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .thousands (thousands),
    .hundreds  (hundreds),
    .tens      (tens),
    .ones      (ones),
    .negative  (negative),
    .Accel_Data(Accel_Data),
    .busy      (busy),
    .done      (done),
    .bcd_err   (bcd_err),
    .sat       (sat)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [15:0] exp_data;
  logic        exp_busy, exp_done, exp_err, exp_sat;
  bit          chk_en = 1'b0;
  bit          b2b_pending = 1'b0;
  int          b2b_mg = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  // Expected {sat, Accel_Data} for a signed mg value, from the encoding rules
  function automatic logic [16:0] model(input int mg);
    int mag;
    int counts;
    int v;
    bit s;
    logic [9:0] v10;
    mag    = (mg < 0) ? -mg : mg;
    counts = mag / 4;
    s      = 1'b0;
    if (mg >= 0 && counts > 511) begin counts = 511; s = 1'b1; end
    if (mg <  0 && counts > 512) begin counts = 512; s = 1'b1; end
    v   = (mg < 0) ? -counts : counts;
    v10 = 10'(v);
    return {s, v10[2:0], 5'b0_0000, v10[9], v10[9:3]};
  endfunction

  // Continuous comparison against the tracked expectations
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy",    16'(busy),    16'(exp_busy));
      check("done",    16'(done),    16'(exp_done));
      check("data",    Accel_Data,   exp_data);
      check("bcd_err", 16'(bcd_err), 16'(exp_err));
      check("sat",     16'(sat),     16'(exp_sat));
    end
  end

  task automatic set_digits(input int mg);
    int mag;
    mag       = (mg < 0) ? -mg : mg;
    thousands = 4'(mag / 1000);
    hundreds  = 4'((mag / 100) % 10);
    tens      = 4'((mag / 10) % 10);
    ones      = 4'(mag % 10);
    negative  = (mg < 0);
  endtask

  task automatic conv(input logic [3:0] th, input logic [3:0] h, input logic [3:0] t,
                      input logic [3:0] o, input bit neg, input bit pre_started,
                      input bit poke_busy);
    bit bad;
    int lat;
    int mg;
    logic [16:0] m;
    bad = (th > 4'd9) || (h > 4'd9) || (t > 4'd9) || (o > 4'd9);
    mg  = int'(th) * 1000 + int'(h) * 100 + int'(t) * 10 + int'(o);
    if (neg) mg = -mg;
    lat = bad ? 2 : 18;
    if (!pre_started) begin
      @(negedge clk);
      thousands = th; hundreds = h; tens = t; ones = o; negative = neg;
      start = 1'b1;
    end
    @(posedge clk); #1;
    start = 1'b0;
    thousands = 4'hF; hundreds = 4'h9; tens = 4'h9; ones = 4'h9; negative = ~neg;
    exp_busy = 1'b1;
    exp_done = 1'b0;
    for (int k = 1; k <= lat; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin exp_err = bad; exp_sat = 1'b0; end
      if (poke_busy && k == 5) begin
        thousands = 4'd5; hundreds = 4'd0; tens = 4'd0; ones = 4'd0; start = 1'b1;
      end
      if (poke_busy && k == 7) start = 1'b0;
      if (k == lat) begin
        exp_busy = 1'b0;
        exp_done = 1'b1;
        if (!bad) begin
          m = model(mg);
          exp_data = m[15:0];
          exp_sat  = m[16];
        end
        if (b2b_pending) begin
          set_digits(b2b_mg);
          start = 1'b1;
        end
      end
    end
    if (!b2b_pending) begin
      @(posedge clk); #1;
      exp_done = 1'b0;
    end
  endtask

  // Pins the model and the DUT's held result to a hand-computed literal
  task automatic pin(input string name, input int mg, input logic [15:0] lit, input bit lit_sat);
    logic [16:0] m;
    m = model(mg);
    check({"model_", name}, m[15:0], lit);
    check({"model_sat_", name}, 16'(m[16]), 16'(lit_sat));
    check({"dut_", name}, Accel_Data, lit);
    check({"dut_sat_", name}, 16'(sat), 16'(lit_sat));
  endtask

  initial begin
    logic [9:0] v10;
    int r;
    int mag;
    rst_n = 1'b0;
    start = 1'b0;
    thousands = '0; hundreds = '0; tens = '0; ones = '0; negative = 1'b0;
    exp_data = '0; exp_busy = 1'b0; exp_done = 1'b0; exp_err = 1'b0; exp_sat = 1'b0;
    #2 chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    conv(4'd1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    pin("p1000", 1000, 16'h401F, 1'b0);
    conv(4'd1, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    pin("m1000", -1000, 16'hC0E0, 1'b0);
    conv(4'd9, 4'd9, 4'd9, 4'd9, 1'b0, 1'b0, 1'b0);
    pin("p9999", 9999, 16'hE03F, 1'b1);
    conv(4'd2, 4'd0, 4'd4, 4'd8, 1'b1, 1'b0, 1'b0);
    pin("m2048", -2048, 16'h00C0, 1'b0);
    conv(4'd2, 4'd0, 4'd5, 4'd2, 1'b1, 1'b0, 1'b0);
    pin("m2052", -2052, 16'h00C0, 1'b1);
    conv(4'd0, 4'd0, 4'd0, 4'd3, 1'b0, 1'b0, 1'b1);
    pin("p0003", 3, 16'h0000, 1'b0);
    conv(4'd0, 4'd0, 4'd0, 4'd3, 1'b1, 1'b0, 1'b0);
    pin("m0003", -3, 16'h0000, 1'b0);
    conv(4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    pin("m0000", 0, 16'h0000, 1'b0);

    // Invalid digit after a valid result
    conv(4'd1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    conv(4'd1, 4'd0, 4'hA, 4'd0, 1'b0, 1'b0, 1'b0);
    check("lit_err_flag", 16'(bcd_err), 16'h0001);
    check("lit_err_data", Accel_Data, 16'h401F);

    // Reset in the middle of SHIFT
    @(negedge clk);
    set_digits(1000);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    exp_busy = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin exp_err = 1'b0; exp_sat = 1'b0; end
    end
    #2 rst_n = 1'b0;
    exp_data = '0; exp_busy = 1'b0; exp_done = 1'b0; exp_err = 1'b0; exp_sat = 1'b0;
    #1;
    check("rst_data", Accel_Data, 16'h0000);
    check("rst_busy", 16'(busy), 16'h0000);
    check("rst_done", 16'(done), 16'h0000);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    conv(4'd1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    pin("p1000_after_rst", 1000, 16'h401F, 1'b0);

    // Back-to-back: next start sampled on the edge leaving DONE
    b2b_pending = 1'b1;
    b2b_mg = 4;
    conv(4'd1, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    b2b_pending = 1'b0;
    conv(4'd0, 4'd0, 4'd0, 4'd4, 1'b0, 1'b1, 1'b0);
    pin("p0004_b2b", 4, 16'h2000, 1'b0);

    // Round trip through the accelerometer decode
    for (int m = -2048; m <= 2044; m += 4) begin
      mag = (m < 0) ? -m : m;
      conv(4'(mag / 1000), 4'((mag / 100) % 10), 4'((mag / 10) % 10), 4'(mag % 10),
           (m < 0), 1'b0, 1'b0);
      v10 = {Accel_Data[6:0], Accel_Data[15:13]};
      r = 4 * int'($signed(v10));
      check("roundtrip", 16'(r), 16'(m));
      check("roundtrip_pad", 16'(Accel_Data[12:8]), 16'h0000);
    end

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
